// File: rtl/bus_xfer_pkg.sv
// Shared types and constants for the bus transfer sequencer.
// Holds the FSM state enum, index-width helper and legal parameter ranges.
package bus_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    LOAD,
    TURN
  } state_t;

  localparam int NREG_MIN = 2;
  localparam int NREG_MAX = 16;
  localparam int NREQ_MIN = 2;
  localparam int NREQ_MAX = 8;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner.
// Ports: clk, rst_n, req, take (advance on grant) -> win_oh, win_idx.
module rr_arbiter
  import bus_xfer_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = idx_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            take,
  output logic [NREQ-1:0] win_oh,
  output logic [AW-1:0]   win_idx
);

  logic [AW-1:0] ptr;
  logic [AW-1:0] k;
  logic          found;
  int            j;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    k       = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      k = j[AW-1:0];
      if (!found && req[k]) begin
        found      = 1'b1;
        win_oh[k]  = 1'b1;
        win_idx    = k;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (take && found) begin
      ptr <= (win_idx == AW'(NREQ - 1)) ? '0
                                        : win_idx + AW'(1);
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Bus transfer sequencer: grants one reg-to-reg move at a time, DRIVE/LOAD/TURN.
// Ports: req/src/dst per requester in; gnt, reg_oe, reg_ld, busy, done, err out.
module bus_xfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter int NREG = 8,
  parameter int NREQ = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*idx_w(NREG)-1:0] src,
  input  logic [NREQ*idx_w(NREG)-1:0] dst,
  output logic [NREQ-1:0]             gnt,
  output logic [NREG-1:0]             reg_oe,
  output logic [NREG-1:0]             reg_ld,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int IDX_W = idx_w(NREG);
  localparam int AW    = idx_w(NREQ);

  if (NREG < NREG_MIN || NREG > NREG_MAX ||
      (NREG & (NREG - 1)) != 0) begin : g_bad_nreg
    $error("bus_xfer_ctrl: illegal NREG");
  end

  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("bus_xfer_ctrl: illegal NREQ");
  end

  state_t           state;
  logic [IDX_W-1:0] src_q;
  logic [IDX_W-1:0] dst_q;
  logic             same_q;
  logic [NREQ-1:0]  win_oh;
  logic [AW-1:0]    win_idx;
  logic [IDX_W-1:0] sel_src;
  logic [IDX_W-1:0] sel_dst;
  logic             any_req;
  logic             take;

  assign any_req = |req;
  assign take    = any_req &&
                   (state == IDLE || state == TURN);

  rr_arbiter #(
    .NREQ (NREQ),
    .AW   (AW)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .take    (take),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

  always_comb begin
    sel_src = '0;
    sel_dst = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == i[AW-1:0]) begin
        sel_src = src[i*IDX_W +: IDX_W];
        sel_dst = dst[i*IDX_W +: IDX_W];
      end
    end
  end

  function automatic logic [NREG-1:0] dec(
    input logic [IDX_W-1:0] idx
  );
    logic [NREG-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // Outputs for the next cycle are set at the edge
  // that enters it, so every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      same_q <= 1'b0;
      gnt    <= '0;
      reg_oe <= '0;
      reg_ld <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      gnt    <= '0;
      reg_ld <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      unique case (state)
        IDLE, TURN: begin
          if (any_req) begin
            state  <= DRIVE;
            gnt    <= win_oh;
            src_q  <= sel_src;
            dst_q  <= sel_dst;
            same_q <= (sel_src == sel_dst);
            err    <= (sel_src == sel_dst);
            busy   <= 1'b1;
            reg_oe <= (sel_src == sel_dst) ? '0
                                           : dec(sel_src);
          end else begin
            state  <= IDLE;
            busy   <= 1'b0;
            reg_oe <= '0;
          end
        end
        DRIVE: begin
          if (same_q) begin
            // Self-move: nothing to load, skip LOAD.
            state  <= TURN;
            reg_oe <= '0;
          end else begin
            state  <= LOAD;
            reg_oe <= dec(src_q);
            reg_ld <= dec(dst_q);
          end
        end
        LOAD: begin
          state  <= TURN;
          reg_oe <= '0;
          done   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed testbench for bus_xfer_ctrl with an expected-snapshot scoreboard.
// Each cycle's expected outputs are queued with the stimulus, popped on check.
module tb_bus_xfer_ctrl;

  localparam int NREG = 8;
  localparam int NREQ = 4;
  localparam int IW   = 3;
  localparam int SW   = NREQ + 2 * NREG + 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req;
  logic [NREQ*IW-1:0] src;
  logic [NREQ*IW-1:0] dst;
  logic [NREQ-1:0]   gnt;
  logic [NREG-1:0]   reg_oe;
  logic [NREG-1:0]   reg_ld;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  bus_xfer_ctrl #(
    .NREG (NREG),
    .NREQ (NREQ)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .src    (src),
    .dst    (dst),
    .gnt    (gnt),
    .reg_oe (reg_oe),
    .reg_ld (reg_ld),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  logic [SW-1:0] expq[$];
  int n_pass = 0;
  int n_tot  = 0;

  wire [SW-1:0] obs = {gnt, reg_oe, reg_ld, busy, done, err};

  function automatic logic [SW-1:0] snap(
    logic [NREQ-1:0] g, logic [NREG-1:0] oe,
    logic [NREG-1:0] ld, logic b, logic dn, logic e
  );
    return {g, oe, ld, b, dn, e};
  endfunction

  task automatic push_idle();
    expq.push_back(snap('0, '0, '0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic push_drive(int r, int s);
    expq.push_back(snap(4'(1 << r), 8'(1 << s), '0,
                        1'b1, 1'b0, 1'b0));
  endtask

  task automatic push_load(int s, int d);
    expq.push_back(snap('0, 8'(1 << s), 8'(1 << d),
                        1'b1, 1'b0, 1'b0));
  endtask

  task automatic push_turn();
    expq.push_back(snap('0, '0, '0, 1'b1, 1'b1, 1'b0));
  endtask

  task automatic push_xfer(int r, int s, int d);
    push_drive(r, s);
    push_load(s, d);
    push_turn();
  endtask

  task automatic set_req(int r, int s, int d);
    src[r*IW +: IW] = 3'(s);
    dst[r*IW +: IW] = 3'(d);
  endtask

  task automatic check_now(string tag);
    logic [SW-1:0] e;
    n_tot++;
    if (expq.size() == 0) begin
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
      return;
    end
    e = expq.pop_front();
    assert (obs === e) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, e);
  endtask

  task automatic step(string tag);
    @(posedge clk);
    @(negedge clk);
    check_now(tag);
  endtask

  initial begin
    req = '0;
    src = '0;
    dst = '0;

    @(negedge clk);
    push_idle();
    check_now("reset_state");

    rst_n = 1'b1;
    set_req(1, 3, 5);
    req = 4'b0010;
    push_xfer(1, 3, 5);
    step("x1_drive");
    req = '0;
    set_req(1, 0, 0);
    step("x1_load");
    step("x1_turn");
    push_idle();
    step("x1_idle");

    set_req(2, 7, 7);
    req = 4'b0100;
    expq.push_back(snap(4'b0100, '0, '0, 1'b1, 1'b0, 1'b1));
    step("same_drive");
    req = '0;
    expq.push_back(snap('0, '0, '0, 1'b1, 1'b0, 1'b0));
    step("same_turn");
    push_idle();
    step("same_idle");

    set_req(0, 1, 6);
    req = 4'b0001;
    push_drive(0, 1);
    push_load(1, 6);
    step("abort_drive");
    req = '0;
    step("abort_load");
    rst_n = 1'b0;
    #1;
    push_idle();
    check_now("reset_async");
    push_idle();
    step("reset_held");

    rst_n = 1'b1;
    set_req(2, 0, 4);
    req = 4'b0100;
    push_xfer(2, 0, 4);
    step("post_rst_drive");
    req = '0;
    step("post_rst_load");
    step("post_rst_turn");
    push_idle();
    step("post_rst_idle");

    rst_n = 1'b0;
    push_idle();
    step("reset2");
    rst_n = 1'b1;

    for (int i = 0; i < NREQ; i++) set_req(i, i, i + 4);
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      push_xfer(i, i, i + 4);
      step($sformatf("rr%0d_drive", i));
      step($sformatf("rr%0d_load", i));
      step($sformatf("rr%0d_turn", i));
    end
    push_xfer(0, 0, 4);
    step("rr0b_drive");
    req = '0;
    step("rr0b_load");
    step("rr0b_turn");
    push_idle();
    step("rr0b_idle");

    req = 4'b1000;
    push_xfer(3, 3, 7);
    step("solo3_drive");
    req = '0;
    step("solo3_load");
    step("solo3_turn");
    push_idle();
    step("solo3_idle");

    req = 4'b1001;
    push_xfer(0, 0, 4);
    step("wrap_drive");
    req = 4'b1000;
    step("wrap_load");
    step("wrap_turn");
    push_xfer(3, 3, 7);
    step("wrap3_drive");
    req = '0;
    step("wrap3_load");
    step("wrap3_turn");
    push_idle();
    step("wrap3_idle");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
